opll_sample_stream: RTL
=======================

// Module: opll_sample_stream
// PURPOSE
// - Frame buffer + channel serialiser between the OPLL sound core and the pin/DAC layer.
// - Accepts one frame of CHANNELS signed two's-complement samples per handshake.
// - Buffers up to DEPTH frames.
// - Emits one offset-binary word per channel over a valid/ready stream.
// - Offset binary: 0x8000 = silence for IN_W=16. Generalises the single fixed 16-bit signed->unsigned pin mapping to N channels, any width, with buffering.
// PARAMETERS
// - IN_W      16  sample width in bits, >=2.
// - CHANNELS  2   samples per frame, >=1; channel 0 = left/mono.
// - DEPTH     4   frame FIFO depth; power of 2, >=2.
// PORTS
// - clk        in   1                    single clock, rising edge.
// - rst        in   1                    asynchronous, active-high reset.
// - in_valid   in   1                    frame available on in_data.
// - in_ready   out  1                    frame can be accepted.
// - in_data    in   CHANNELS*IN_W        signed samples; ch k = bits [k*IN_W +: IN_W].
// - out_valid  out  1                    out_data holds a valid word.
// - out_ready  in   1                    consumer accepts word.
// - out_data   out  IN_W                 offset-binary sample.
// - out_ch     out  max(1,$clog2(CHANNELS))  channel index of out_data.
// - out_first  out  1                    high when out_ch==0; frame marker.
// - level      out  $clog2(DEPTH)+1      frames stored, including the in-flight frame; 0..DEPTH.
// - overflow   out  1                    sticky flag; cleared by clr_ovf or rst.
// - clr_ovf    in   1                    clears overflow. Same-cycle set wins.
// BEHAVIOUR
// - Reset values: level=0, out_valid=0, out_ch=0, out_first=1, out_data=0, overflow=0.
//   in_ready=1 after reset. Pointers are cleared.
// - Outputs depend only on registered state; there is no combinational in->out path.
// - push = in_valid & in_ready.
//   - Writes in_data at the tail pointer and increments the tail pointer mod DEPTH.
// - out_valid = (level!=0).
// - out_data = head_frame[out_ch] ^ (1<<(IN_W-1)).
//   - Equals signed + 2^(IN_W-1), mod 2^IN_W. No saturation.
// - Word transfer = out_valid & out_ready.
//   - If out_ch < CHANNELS-1: out_ch is incremented.
//   - Otherwise: out_ch goes to 0, the head pointer is incremented, and the frame is popped.
// - Latency: a push into an empty buffer at edge N gives out_valid=1 and ch0 data after edge N.
// - out_data/out_ch are stable while out_valid & !out_ready.
// - level update each cycle: level += push - pop. Simultaneous push and pop leaves level unchanged.
// - Full (level==DEPTH), default build:
//   - in_ready=0.
//   - in_valid while full sets overflow; the frame is not stored.
//   - A pop and an attempted push in the same cycle while full: the push is refused (in_ready was 0) and overflow is set.
// - Empty (level==0): out_valid=0. A pop cannot occur.
// - Pointers wrap mod DEPTH. level distinguishes full from empty.
// - CHANNELS=1: out_ch is held at 0, and every transfer pops a frame.
// - rst asserted mid-frame: the partial frame and all buffered frames are discarded. out_ch returns to 0.
// CONFIGURATION
// - Macro OPLL_STREAM_OVERWRITE_EN.
// - Defined (lossy, real-time mode):
//   - in_ready is constantly 1.
//   - A push while full, with no pop in the same cycle:
//     - replaces the most recently stored frame at tail-1; the pointer and level are unchanged;
//     - sets overflow.
//   - The in-flight head frame is never modified. DEPTH>=2 guarantees tail-1 != head.
//   - Push while full together with a pop: normal push, no overwrite, overflow unchanged.
// - Undefined: backpressure behaviour as in BEHAVIOUR.
// TESTING
// 1. Reset: rst=1 with random inputs -> after release: level=0, out_valid=0, overflow=0, in_ready=1, out_first=1.
// 2. Conversion, IN_W=16, CHANNELS=2, out_ready=1. Push {ch1=16'h7FFF, ch0=16'h8000}. Required:
//    - next edge: out_data=0000, out_ch=0, out_first=1;
//    - following edge: out_data=FFFF, out_ch=1;
//    - then out_valid=0.
//    - Also push ch0=0 -> out_data=8000.
// 3. Stall: out_ready=0 for 5 cycles mid-frame -> out_data/out_ch held, level unchanged. Release -> words resume in order.
// 4. Full, default build: out_ready=0, push 5 frames (DEPTH=4) -> level=4, in_ready=0 after the 4th, overflow=1. Drain -> frames 1..4 in order; frame 5 absent.
// 5. OPLL_STREAM_OVERWRITE_EN, out_ready=0, push frames A,B,C,D,E -> level=4, overflow=1. Drain order = A,B,C,E.
// 6. Wrap and concurrency: 20 frames with random in_valid/out_ready -> ordering preserved across pointer wrap.
//    - Push+pop in the same cycle keeps level constant.
//    - Compare against a scoreboard model.
//    - clr_ovf pulse -> overflow=0 the next cycle.

Source files
------------

// File: rtl/opll_sample_stream.sv
// Frame FIFO plus channel serialiser. It converts signed OPLL samples to offset-binary words on a valid/ready stream.
// Define OPLL_STREAM_OVERWRITE_EN to build the lossy mode, where a push into a full buffer overwrites the newest frame.
module opll_sample_stream #(
  parameter int IN_W     = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [CHANNELS*IN_W-1:0]                        in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [IN_W-1:0]                                 out_data,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_ch,
  output logic                                            out_first,
  output logic [$clog2(DEPTH):0]                          level,
  output logic                                            overflow,
  input  logic                                            clr_ovf
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int FR_W  = CHANNELS * IN_W;

  logic [FR_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, wr_ptr;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             ovf_q, ovf_d;
  logic             full, xfer, last_ch, pop, push, wr_en, ovf_set;
  logic [FR_W-1:0]  head_frame;

  always_comb begin
    full      = (level_q == LVL_W'(DEPTH));
    out_valid = (level_q != '0);
    last_ch   = (ch_q == CH_W'(CHANNELS - 1));
    xfer      = out_valid & out_ready;
    pop       = xfer & last_ch;
`ifdef OPLL_STREAM_OVERWRITE_EN
    // A pop in the same cycle frees a slot, so the push proceeds normally.
    // Otherwise, the newest frame at tail-1 is replaced. It is never the head frame.
    in_ready  = 1'b1;
    push      = in_valid & (~full | pop);
    wr_en     = in_valid;
    ovf_set   = in_valid & full & ~pop;
    wr_ptr    = push ? tail_q : tail_q - 1'b1;
`else
    in_ready  = ~full;
    push      = in_valid & ~full;
    wr_en     = push;
    ovf_set   = in_valid & full;
    wr_ptr    = tail_q;
`endif
    tail_d    = push ? tail_q + 1'b1 : tail_q;
    head_d    = pop ? head_q + 1'b1 : head_q;
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
    ch_d      = xfer ? (last_ch ? '0 : ch_q + 1'b1) : ch_q;
    ovf_d     = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    head_frame = mem_q[head_q];
    // Flipping the MSB converts two's complement to offset binary.
    out_data  = out_valid ? (head_frame[int'(ch_q)*IN_W +: IN_W] ^ {1'b1, {(IN_W-1){1'b0}}})
                          : '0;
    out_ch    = ch_q;
    out_first = (ch_q == '0);
    level     = level_q;
    overflow  = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
      if (wr_en) mem_q[wr_ptr] <= in_data;
    end
  end

endmodule
